// File: rtl/awb_pkg.sv
// Shared definitions for the AWB statistics sequencer.
// Holds the sequencer state encoding, the colour-plane codes driven to the
// mean accumulator, the size and watchdog limits, and a helper that returns
// the index of the last pixel in a plane.
package awb_pkg;

  localparam int unsigned CNT_W    = 21;  // wide enough for 2^20 pixels per plane
  localparam int unsigned SIZE_W   = 5;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned MAX_SIZE = 20;
  localparam int unsigned WD_LIMIT = 8;   // WAIT cycles allowed before a timeout

  // Sequencer states; a plain binary encoding keeps legacy tools happy.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN_R = 3'd1;
  localparam logic [2:0] ST_RUN_G = 3'd2;
  localparam logic [2:0] ST_RUN_B = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2
  } color_e;

  // Index of the final pixel of a plane holding 2^size pixels.
  function automatic logic [CNT_W-1:0] plane_last(input logic [SIZE_W-1:0] size);
    return (CNT_W'(1) << size) - CNT_W'(1);
  endfunction

endpackage

// File: rtl/awb_stat_seq_if.sv
// Pixel stream plus mean-accumulator link of the AWB statistics sequencer.
//   pix_valid/pix_data/pix_ready : incoming planar pixel stream
//   mean_valid/color/value/last/size : per-pixel drive to the mean accumulator
//   mean_last_i, r/g/b_mean_i    : results coming back from the accumulator
// The sequencer connects through the slave modport, the surrounding logic
// (pixel source and accumulator) through the master modport.
interface awb_stat_seq_if;
  import awb_pkg::*;

  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_ready;

  logic              mean_valid;
  logic [1:0]        mean_color;
  logic [PIX_W-1:0]  mean_value;
  logic              mean_last;
  logic [SIZE_W-1:0] mean_size;

  logic              mean_last_i;
  logic [PIX_W-1:0]  r_mean_i;
  logic [PIX_W-1:0]  g_mean_i;
  logic [PIX_W-1:0]  b_mean_i;

  modport slave (
    input  pix_valid, pix_data, mean_last_i, r_mean_i, g_mean_i, b_mean_i,
    output pix_ready, mean_valid, mean_color, mean_value, mean_last, mean_size
  );

  modport master (
    output pix_valid, pix_data, mean_last_i, r_mean_i, g_mean_i, b_mean_i,
    input  pix_ready, mean_valid, mean_color, mean_value, mean_last, mean_size
  );

endinterface

// File: rtl/awb_stat_seq.sv
// AWB statistics sequencer.
// Walks one planar frame (R, G, B planes of 2^size pixels each) from the
// pixel stream into an external mean accumulator, then waits for the
// accumulator's result and captures the three channel means.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, cfg_size    : frame request and log2 pixels-per-plane (0..20)
//   bus                : pixel stream + accumulator link (slave modport)
//   busy, done         : frame in progress / one-cycle completion pulse
//   r/g/b_mean         : captured channel means
//   err_cfg, err_to    : one-cycle pulses for a rejected start / result timeout
// DONE is terminal: the accumulator cannot be cleared, so only rst_n rearms.
module awb_stat_seq
  import awb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SIZE_W-1:0] cfg_size,
  awb_stat_seq_if.slave     bus,
  output logic              busy,
  output logic              done,
  output logic [PIX_W-1:0]  r_mean,
  output logic [PIX_W-1:0]  g_mean,
  output logic [PIX_W-1:0]  b_mean,
  output logic              err_cfg,
  output logic              err_to
);

  logic [2:0]        state_q,   state_d;
  logic [SIZE_W-1:0] size_q,    size_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [2:0]        wd_q,      wd_d;
  logic [PIX_W-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic              done_q,    done_d;
  logic              err_cfg_q, err_cfg_d;
  logic              err_to_q,  err_to_d;

  logic   run;
  logic   xfer;
  logic   last_hit;
  color_e color;

  assign run      = (state_q == ST_RUN_R) || (state_q == ST_RUN_G) || (state_q == ST_RUN_B);
  assign xfer     = bus.pix_valid & run;
  // Qualified by xfer so the accumulator never sees a last without a beat.
  assign last_hit = xfer & (cnt_q == plane_last(size_q));

  always_comb begin
    color = RED;
    case (state_q)
      ST_RUN_G: color = GREEN;
      ST_RUN_B: color = BLUE;
      default:  color = RED;
    endcase
  end

  assign bus.pix_ready  = run;
  assign bus.mean_valid = xfer;
  assign bus.mean_value = bus.pix_data;
  assign bus.mean_color = color;
  assign bus.mean_last  = last_hit;
  assign bus.mean_size  = size_q;

  assign busy    = run | (state_q == ST_WAIT);
  assign done    = done_q;
  assign err_cfg = err_cfg_q;
  assign err_to  = err_to_q;
  assign r_mean  = r_q;
  assign g_mean  = g_q;
  assign b_mean  = b_q;

  always_comb begin
    // NOTE: every _d starts from its _q (pulses from 0) so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    size_d    = size_q;
    cnt_d     = cnt_q;
    wd_d      = wd_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    done_d    = 1'b0;
    err_cfg_d = 1'b0;
    err_to_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_size > SIZE_W'(MAX_SIZE)) begin
            err_cfg_d = 1'b1;
          end else begin
            size_d  = cfg_size;
            cnt_d   = '0;
            state_d = ST_RUN_R;
          end
        end
      end

      ST_RUN_R, ST_RUN_G, ST_RUN_B: begin
        if (xfer) begin
          if (last_hit) begin
            cnt_d = '0;
            case (state_q)
              ST_RUN_R: state_d = ST_RUN_G;
              ST_RUN_G: state_d = ST_RUN_B;
              default: begin
                state_d = ST_WAIT;
                wd_d    = '0;
              end
            endcase
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_WAIT: begin
        if (bus.mean_last_i) begin
          r_d     = bus.r_mean_i;
          g_d     = bus.g_mean_i;
          b_d     = bus.b_mean_i;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (wd_q == 3'(WD_LIMIT - 1)) begin
          err_to_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          wd_d = wd_q + 3'd1;
        end
      end

      ST_DONE: begin
        if (start) err_cfg_d = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; all registers, including the captured means, reset so
    // an abandoned frame leaves nothing stale behind.
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      size_q    <= '0;
      cnt_q     <= '0;
      wd_q      <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      done_q    <= 1'b0;
      err_cfg_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      done_q    <= done_d;
      err_cfg_q <= err_cfg_d;
      err_to_q  <= err_to_d;
    end
  end

endmodule
